// File: rtl/io_result_encoder_if.sv
// Bus bundle between the result encoder and its neighbours: the result RAM
// read port, the shared 32-bit IO data bus and the start/busy/done control.
// The master modport is the encoder side, the slave modport the environment side.
interface io_result_encoder_if #(
  parameter int ADDR_W = 64
);
  logic              start;
  logic [5:0]        count;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       rd_data;
  logic [31:0]       data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, count, rd_data, data_ready,
    output ram_rd, ram_addr, data_out, data_valid, busy, done
  );

  modport slave (
    output start, count, rd_data, data_ready,
    input  ram_rd, ram_addr, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/io_result_encoder.sv
// io_result_encoder: reads COUNT fixed-point results from the result RAM,
// serialises them MSB first, run-length encodes the bit stream into
// {bit, len[2:0]} nibbles and emits packed 32-bit words (nibble 0 in
// bits[31:28], unused slots padded with 4'h0).
// Optional feature macro: IO_ENC_HEADER_EN -- when defined, the 6-bit count
// is shifted MSB first into the run encoder ahead of element 0.
module io_result_encoder #(
  parameter int                ELEM_W    = 16,
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_RUN   = 7
) (
  input  logic                clk,
  input  logic                rst,
  io_result_encoder_if.master io
);

  localparam int         BW      = $clog2(ELEM_W + 1);
  localparam logic [2:0] MAX_LEN = 3'(MAX_RUN);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_FLUSH, S_EMIT
  } state_t;

  state_t            state_q;
  logic [5:0]        cnt_q;
  logic [5:0]        idx_q;
  logic [ELEM_W-1:0] sreg_q;
  logic [BW-1:0]     bits_q;
  logic              ram_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
`ifdef IO_ENC_HEADER_EN
  logic              hdr_q;
`endif

  // run encoder and word buffer state, with next-state values
  logic        run_bit_q, run_bit_d;
  logic [2:0]  run_len_q, run_len_d;
  logic [31:0] buf_q,     buf_d;
  logic [2:0]  nib_q,     nib_d;
  logic [31:0] dout_q,    dout_d;
  logic        dv_q,      dv_d;

  logic        stall, accept, shift_go, flush_go, cur_bit, close, push;
  logic [5:0]  next_idx;
  logic        unused_ok;

  // Only the low ELEM_W bits of the RAM word carry the result.
  assign unused_ok = ^io.rd_data[63:ELEM_W];
  assign next_idx  = idx_q + 6'd1;

  // Place nibble n into word slot 'slot' (slot 0 = bits[31:28]).
  function automatic logic [31:0] put_nibble(input logic [31:0] w,
                                             input logic [2:0]  slot,
                                             input logic [3:0]  n);
    return w | ({n, 28'h0} >> {slot, 2'b00});
  endfunction

  // Run-length encoder, nibble packing and output word hand-off.
  always_comb begin
    stall     = dv_q && !io.data_ready;
    accept    = dv_q && io.data_ready;
    shift_go  = (state_q == S_SHIFT) && !stall;
    flush_go  = (state_q == S_FLUSH) && !stall;
    cur_bit   = sreg_q[ELEM_W-1];
    run_bit_d = run_bit_q;
    run_len_d = run_len_q;
    buf_d     = buf_q;
    nib_d     = nib_q;
    dout_d    = dout_q;
    dv_d      = accept ? 1'b0 : dv_q;
    close     = 1'b0;
    push      = 1'b0;
    if (shift_go) begin
      if ((run_len_q != 3'd0) && (cur_bit == run_bit_q) && (run_len_q < MAX_LEN)) begin
        run_len_d = run_len_q + 3'd1;
      end else begin
        close     = (run_len_q != 3'd0);
        run_bit_d = cur_bit;
        run_len_d = 3'd1;
      end
    end else if (flush_go) begin
      close     = (run_len_q != 3'd0);
      run_bit_d = 1'b0;
      run_len_d = 3'd0;
    end
    if (close) begin
      buf_d = put_nibble(buf_q, nib_q, {run_bit_q, run_len_q});
      nib_d = nib_q + 3'd1;
    end
    // Full word, or a partially filled word at the end of the stream.
    push = (close && (nib_q == 3'd7)) || (flush_go && (close || (nib_q != 3'd0)));
    if (push) begin
      dout_d = buf_d;
      dv_d   = 1'b1;
      buf_d  = '0;
      nib_d  = 3'd0;
    end
  end

  // Transfer sequencer with registered outputs; also commits encoder state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sreg_q    <= '0;
      bits_q    <= '0;
      ram_rd_q  <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      run_bit_q <= 1'b0;
      run_len_q <= '0;
      buf_q     <= '0;
      nib_q     <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
`ifdef IO_ENC_HEADER_EN
      hdr_q     <= 1'b0;
`endif
    end else begin
      run_bit_q <= run_bit_d;
      run_len_q <= run_len_d;
      buf_q     <= buf_d;
      nib_q     <= nib_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      done_q    <= 1'b0;
      ram_rd_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (io.start) begin
            cnt_q  <= io.count;
            idx_q  <= '0;
            busy_q <= 1'b1;
`ifdef IO_ENC_HEADER_EN
            sreg_q  <= {io.count, {(ELEM_W-6){1'b0}}};
            bits_q  <= BW'(6);
            hdr_q   <= 1'b1;
            state_q <= S_SHIFT;
`else
            if (io.count == 6'd0) begin
              state_q <= S_EMIT;
            end else begin
              ram_rd_q <= 1'b1;
              addr_q   <= BASE_ADDR;
              state_q  <= S_FETCH;
            end
`endif
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          sreg_q  <= io.rd_data[ELEM_W-1:0];
          bits_q  <= BW'(ELEM_W);
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_go) begin
            sreg_q <= {sreg_q[ELEM_W-2:0], 1'b0};
            bits_q <= bits_q - BW'(1);
            if (bits_q == BW'(1)) begin
`ifdef IO_ENC_HEADER_EN
              if (hdr_q) begin
                hdr_q <= 1'b0;
                if (cnt_q != 6'd0) begin
                  ram_rd_q <= 1'b1;
                  addr_q   <= BASE_ADDR;
                  state_q  <= S_FETCH;
                end else begin
                  state_q <= S_FLUSH;
                end
              end else
`endif
              begin
                idx_q <= next_idx;
                if (next_idx < cnt_q) begin
                  ram_rd_q <= 1'b1;
                  addr_q   <= BASE_ADDR + ADDR_W'({next_idx, 2'b00});
                  state_q  <= S_FETCH;
                end else begin
                  state_q <= S_FLUSH;
                end
              end
            end
          end
        end
        S_FLUSH: begin
          if (flush_go) state_q <= S_EMIT;
        end
        S_EMIT: begin
          if (!dv_q || io.data_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign io.ram_rd     = ram_rd_q;
  assign io.ram_addr   = addr_q;
  assign io.data_out   = dout_q;
  assign io.data_valid = dv_q;
  assign io.busy       = busy_q;
  assign io.done       = done_q;

endmodule

// File: tb/tb_io_result_encoder.sv
// Directed bench for io_result_encoder: table of single/dual element
// transfers with hand-encoded words, plus sequences for count=0 timing,
// backpressure, start-while-busy and reset mid-transfer.
module tb_io_result_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_result_encoder_if #(.ADDR_W(64)) bus();

  io_result_encoder #(
    .ELEM_W(16), .ADDR_W(64), .BASE_ADDR(64'd0), .MAX_RUN(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  typedef struct {
    logic [5:0]  cnt;
    logic [15:0] d0;
    logic [15:0] d1;
    int          nwords;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] mem [0:63];
  logic [31:0] words[$];
  logic [63:0] addrs[$];
  int          rd_cyc[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
`ifdef IO_ENC_HEADER_EN
  localparam logic [31:0] ZERO_WORD = 32'h5977_2000;
`else
  localparam logic [31:0] ZERO_WORD = 32'h7720_0000;
`endif

  // Bus monitor and RAM model, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (bus.data_valid && bus.data_ready) words.push_back(bus.data_out);
      if (bus.ram_rd) begin
        addrs.push_back(bus.ram_addr);
        rd_cyc.push_back(cyc);
        bus.rd_data = mem[bus.ram_addr[7:2]];
      end
      if (bus.done) done_cnt = done_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    words.delete();
    addrs.delete();
    rd_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [5:0] c);
    bus.start = 1'b1;
    bus.count = c;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
    chk({nm, "_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    bus.data_ready = 1'b1;
`ifdef IO_ENC_HEADER_EN
    vecs.push_back('{6'd1, 16'h0000, 16'h0000, 1, 32'h5977_2000, 32'h0});
    vecs.push_back('{6'd1, 16'hFFFF, 16'h0000, 1, 32'h5FFB_0000, 32'h0});
    vecs.push_back('{6'd2, 16'h0000, 16'h0000, 1, 32'h4977_7750, 32'h0});
    vecs.push_back('{6'd0, 16'h0000, 16'h0000, 1, 32'h6000_0000, 32'h0});
`else
    vecs.push_back('{6'd1, 16'h0000, 16'h0000, 1, 32'h7720_0000, 32'h0});
    vecs.push_back('{6'd1, 16'hFFFF, 16'h0000, 1, 32'hFFA0_0000, 32'h0});
    vecs.push_back('{6'd1, 16'hAAAA, 16'h0000, 2, 32'h9191_9191, 32'h9191_9191});
    vecs.push_back('{6'd2, 16'h0000, 16'h0000, 1, 32'h7777_4000, 32'h0});
    vecs.push_back('{6'd1, 16'h8000, 16'h0000, 1, 32'h9771_0000, 32'h0});
    vecs.push_back('{6'd1, 16'hFE00, 16'h0000, 1, 32'hF720_0000, 32'h0});
    vecs.push_back('{6'd2, 16'hFFFF, 16'h0000, 1, 32'hFFA7_7200, 32'h0});
`endif

    repeat (3) tick();
    chk("rst_valid", 64'(bus.data_valid), 64'd0);
    chk("rst_dout",  64'(bus.data_out),   64'd0);
    chk("rst_busy",  64'(bus.busy),       64'd0);
    chk("rst_done",  64'(bus.done),       64'd0);
    chk("rst_ramrd", 64'(bus.ram_rd),     64'd0);
    chk("rst_addr",  bus.ram_addr,        64'd0);
    rst = 1'b0;
    tick();

    // table-driven transfers
    foreach (vecs[v]) begin
      mem[0] = {48'hDEAD_BEEF_0123, vecs[v].d0};
      mem[1] = {48'h5A5A_A5A5_FFFF, vecs[v].d1};
      clear_mon();
      pulse_start(vecs[v].cnt);
      wait_done($sformatf("v%0d_done", v));
      chk($sformatf("v%0d_nwords", v), 64'(words.size()), 64'(vecs[v].nwords));
      for (int k = 0; k < vecs[v].nwords && k < words.size(); k++)
        chk($sformatf("v%0d_word%0d", v, k), 64'(words[k]), 64'(k == 0 ? vecs[v].w0 : vecs[v].w1));
      chk($sformatf("v%0d_nreads", v), 64'(addrs.size()), 64'(vecs[v].cnt));
      for (int k = 0; k < addrs.size() && k < int'(vecs[v].cnt); k++)
        chk($sformatf("v%0d_addr%0d", v, k), addrs[k], 64'(4 * k));
      if (rd_cyc.size() == 2)
        chk($sformatf("v%0d_rd_spacing", v), 64'(rd_cyc[1] - rd_cyc[0]), 64'd18);
      chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d_busy_end", v), 64'(bus.busy), 64'd0);
    end

`ifndef IO_ENC_HEADER_EN
    // count=0: no reads, no words, done two cycles after start
    clear_mon();
    pulse_start(6'd0);
    chk("c0_busy", 64'(bus.busy), 64'd1);
    chk("c0_ramrd", 64'(bus.ram_rd), 64'd0);
    tick();
    chk("c0_done", 64'(bus.done), 64'd1);
    tick();
    chk("c0_done_low", 64'(bus.done), 64'd0);
    chk("c0_busy_low", 64'(bus.busy), 64'd0);
    chk("c0_nwords", 64'(words.size()), 64'd0);
    chk("c0_nreads", 64'(addrs.size()), 64'd0);
    repeat (2) tick();
`endif

    // backpressure: word held stable, done only after acceptance
    mem[0] = 64'h0;
    clear_mon();
    bus.data_ready = 1'b0;
    pulse_start(6'd1);
`ifndef IO_ENC_HEADER_EN
    chk("bp_first_read", 64'(bus.ram_rd), 64'd1);
    chk("bp_first_addr", bus.ram_addr, 64'd0);
`endif
    for (int i = 0; i < 200 && !bus.data_valid; i++) tick();
    chk("bp_valid_seen", 64'(bus.data_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_valid%0d", i), 64'(bus.data_valid), 64'd1);
      chk($sformatf("bp_hold_dout%0d", i), 64'(bus.data_out), 64'(ZERO_WORD));
      chk($sformatf("bp_no_done%0d", i), 64'(done_cnt), 64'd0);
    end
    bus.data_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_nwords", 64'(words.size()), 64'd1);
    if (words.size() > 0) chk("bp_word", 64'(words[0]), 64'(ZERO_WORD));
    chk("bp_valid_end", 64'(bus.data_valid), 64'd0);

    // start while busy is ignored
    clear_mon();
    pulse_start(6'd1);
    repeat (5) tick();
    pulse_start(6'd3);
    wait_done("sb_done");
    chk("sb_nreads", 64'(addrs.size()), 64'd1);
    chk("sb_nwords", 64'(words.size()), 64'd1);
    chk("sb_done_cnt", 64'(done_cnt), 64'd1);

    // reset in the middle of SHIFT aborts without a flush
    clear_mon();
    mem[0] = 64'hFFFF;
    mem[1] = 64'h0;
    pulse_start(6'd2);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    chk("mr_valid", 64'(bus.data_valid), 64'd0);
    chk("mr_dout",  64'(bus.data_out),   64'd0);
    chk("mr_busy",  64'(bus.busy),       64'd0);
    chk("mr_done",  64'(bus.done),       64'd0);
    chk("mr_ramrd", 64'(bus.ram_rd),     64'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("mr_idle_ramrd", 64'(bus.ram_rd), 64'd0);
    chk("mr_idle_busy",  64'(bus.busy),   64'd0);
    chk("mr_idle_valid", 64'(bus.data_valid), 64'd0);
    mem[0] = 64'h0;
    clear_mon();
    pulse_start(6'd1);
    wait_done("mr_recover_done");
    chk("mr_recover_nwords", 64'(words.size()), 64'd1);
    if (words.size() > 0) chk("mr_recover_word", 64'(words[0]), 64'(ZERO_WORD));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
